essential_bit_encoder: RTL and testbench



---
 rtl/essential_bit_encoder.sv | 107 ++++++++++
 tb/tb_essential_bit_encoder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/essential_bit_encoder.sv
// Streams the set-bit positions of each accepted operand, one shift index per beat.
// Define ESSENTIAL_BIT_MSB_FIRST_EN to emit the highest set bit first instead of the lowest.
module essential_bit_encoder #(
  parameter int bitsize = 8,
  localparam int IW = $clog2(bitsize)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [bitsize-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IW-1:0]      out_shift,
  output logic               out_last,
  output logic               out_zero,
  output logic [IW:0]        out_count
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t             state, state_next;
  logic [bitsize-1:0] residue, residue_next;
  logic [IW:0]        count, count_next;
  logic               zero_flag, zero_next;

  logic               accept;
  logic               beat_fire;
  logic               single_bit;
  logic [bitsize-1:0] clear_mask;

  function automatic logic [IW-1:0] lowest_index(input logic [bitsize-1:0] v);
    lowest_index = '0;
    for (int i = bitsize - 1; i >= 0; i--) begin
      if (v[i]) lowest_index = IW'(i);
    end
  endfunction

  function automatic logic [IW-1:0] highest_index(input logic [bitsize-1:0] v);
    highest_index = '0;
    for (int i = 0; i < bitsize; i++) begin
      if (v[i]) highest_index = IW'(i);
    end
  endfunction

`ifdef ESSENTIAL_BIT_MSB_FIRST_EN
  assign out_shift = highest_index(residue);
`else
  assign out_shift = lowest_index(residue);
`endif

  // A residue with at most one set bit is on its final beat; this also covers a zero operand.
  assign single_bit = ((residue & (residue - bitsize'(1))) == '0);

  assign out_valid  = (state == EMIT);
  assign out_last   = out_valid && single_bit;
  assign out_zero   = zero_flag;
  assign out_count  = count;
  assign in_ready   = (state == IDLE) || (out_valid && out_last && out_ready);

  assign accept     = in_valid && in_ready;
  assign beat_fire  = out_valid && out_ready;
  assign clear_mask = {{(bitsize-1){1'b0}}, 1'b1} << out_shift;

  always_comb begin
    state_next   = state;
    residue_next = residue;
    count_next   = count;
    zero_next    = zero_flag;

    // Accept wins over the last-beat retirement so back-to-back operands need no bubble.
    if (accept) begin
      state_next   = EMIT;
      residue_next = in_data;
      count_next   = '0;
      zero_next    = (in_data == '0);
    end else if (beat_fire) begin
      if (out_last) begin
        state_next   = IDLE;
        residue_next = '0;
        count_next   = '0;
        zero_next    = 1'b0;
      end else begin
        residue_next = residue & ~clear_mask;
        count_next   = count + (IW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      residue   <= '0;
      count     <= '0;
      zero_flag <= 1'b0;
    end else begin
      state     <= state_next;
      residue   <= residue_next;
      count     <= count_next;
      zero_flag <= zero_next;
    end
  end

endmodule

// File: tb/tb_essential_bit_encoder.sv
// Directed bench for essential_bit_encoder at bitsize 8; expected beat tables are written out by hand.
module tb_essential_bit_encoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_shift;
  logic       out_last;
  logic       out_zero;
  logic [3:0] out_count;

  int checkCount = 0;
  int errorCount = 0;

  int expA6[4];
  int expFF[8];
  int expF0[2];
  int exp03[2];

  essential_bit_encoder #(.bitsize(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_shift (out_shift),
    .out_last  (out_last),
    .out_zero  (out_zero),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Presents one operand for a single cycle; the accept happens at the next rising edge.
  task automatic applyStimulus(input logic [7:0] data);
    in_valid = 1'b1;
    in_data  = data;
    #1;
    checkOutput("accept_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'h5A;
  endtask

  task automatic checkBeat(input string tag, input int shift, input int cnt, input logic last, input logic zero);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_shift"}, 32'(out_shift), 32'(shift));
    checkOutput({tag, "_count"}, 32'(out_count), 32'(cnt));
    checkOutput({tag, "_last"},  32'(out_last),  32'(last));
    checkOutput({tag, "_zero"},  32'(out_zero),  32'(zero));
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_ready"}, 32'(in_ready),  32'd1);
  endtask

  initial begin
`ifdef ESSENTIAL_BIT_MSB_FIRST_EN
    expA6 = '{7, 5, 2, 1};
    expFF = '{7, 6, 5, 4, 3, 2, 1, 0};
    expF0 = '{7, 6};
    exp03 = '{1, 0};
`else
    expA6 = '{1, 2, 5, 7};
    expFF = '{0, 1, 2, 3, 4, 5, 6, 7};
    expF0 = '{4, 5};
    exp03 = '{0, 1};
`endif
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkIdle("rst");
    checkOutput("rst_shift", 32'(out_shift), 32'd0);
    checkOutput("rst_last",  32'(out_last),  32'd0);
    checkOutput("rst_zero",  32'(out_zero),  32'd0);
    checkOutput("rst_count", 32'(out_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] operand 8'hA6 with out_ready high");
    out_ready = 1'b1;
    applyStimulus(8'hA6);
    for (int i = 0; i < 4; i++) begin
      #1;
      checkBeat($sformatf("a6_b%0d", i), expA6[i], i, (i == 3), 1'b0);
      @(negedge clk);
    end
    #1;
    checkIdle("a6_done");

    $display("[TB] zero operand");
    @(negedge clk);
    applyStimulus(8'h00);
    #1;
    checkBeat("zero_b0", 0, 0, 1'b1, 1'b1);
    checkOutput("zero_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    #1;
    checkIdle("zero_done");

    $display("[TB] operand 8'hFF with out_ready toggling");
    @(negedge clk);
    applyStimulus(8'hFF);
    for (int i = 0; i < 8; i++) begin
      out_ready = 1'b0;
      #1;
      checkBeat($sformatf("ff_hold%0d", i), expFF[i], i, (i == 7), 1'b0);
      checkOutput($sformatf("ff_hold%0d_ready", i), 32'(in_ready), 32'd0);
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      checkBeat($sformatf("ff_go%0d", i), expFF[i], i, (i == 7), 1'b0);
      @(negedge clk);
    end
    #1;
    checkIdle("ff_done");

    $display("[TB] back-to-back 8'h01 then 8'h80");
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h01;
    @(negedge clk);
    in_data  = 8'h80;
    #1;
    checkBeat("b2b_first", 0, 0, 1'b1, 1'b0);
    checkOutput("b2b_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checkBeat("b2b_second", 7, 0, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    checkIdle("b2b_done");

    $display("[TB] reset in the middle of 8'hF0");
    @(negedge clk);
    applyStimulus(8'hF0);
    for (int i = 0; i < 2; i++) begin
      #1;
      checkBeat($sformatf("f0_b%0d", i), expF0[i], i, 1'b0, 1'b0);
      @(negedge clk);
    end
    reset = 1'b1;
    #1;
    checkIdle("midrst");
    checkOutput("midrst_count", 32'(out_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    applyStimulus(8'h03);
    for (int i = 0; i < 2; i++) begin
      #1;
      checkBeat($sformatf("p03_b%0d", i), exp03[i], i, (i == 1), 1'b0);
      @(negedge clk);
    end
    #1;
    checkIdle("p03_done");

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation did not complete");
  end

endmodule
